// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_pkg;

  // Operation codes as decoded by the execute stage (0 = no operation)
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with fixed multi-cycle latency and architectural HI/LO.
// The result is computed in the sampling cycle into shadow registers and only
// copied to HI/LO when the latency counter expires, so HI/LO stay stable while
// busy is high and an aborted operation leaves no trace.
module md_unit
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  md_state_e   r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic        r_res_ok;   // cleared for divide-by-zero so HI/LO are kept

  md_state_e   w_state_next;
  logic [3:0]  w_cnt_next;
  logic        w_busy_next;
  logic [31:0] w_hi_next;
  logic [31:0] w_lo_next;
  logic [31:0] w_res_hi_next;
  logic [31:0] w_res_lo_next;
  logic        w_res_ok_next;

  md_op_e             w_op;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic [31:0]        w_divisor;
  logic signed [31:0] w_quo_raw;
  logic signed [31:0] w_rem_raw;
  logic [31:0]        w_quo_s;
  logic [31:0]        w_rem_s;
  logic [31:0]        w_quo_u;
  logic [31:0]        w_rem_u;

  assign w_op = md_op_e'(op);

  // Products: operands widened to 64 bits with the appropriate extension
  assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Divisor is forced to 1 for the zero and overflow cases so the divider
  // never sees an undefined operation; those results are overridden/discarded.
  assign w_div_zero = (b == 32'd0);
  assign w_div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign w_divisor  = (w_div_zero || w_div_ovf) ? 32'd1 : b;
  assign w_quo_raw  = $signed(a) / $signed(w_divisor);
  assign w_rem_raw  = $signed(a) % $signed(w_divisor);
  assign w_quo_s    = w_div_ovf ? 32'h8000_0000 : w_quo_raw;
  assign w_rem_s    = w_div_ovf ? 32'd0 : w_rem_raw;
  assign w_quo_u    = a / w_divisor;
  assign w_rem_u    = a % w_divisor;

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // State and datapath registers; reset discards any in-flight result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_res_ok <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_busy   <= w_busy_next;
      r_hi     <= w_hi_next;
      r_lo     <= w_lo_next;
      r_res_hi <= w_res_hi_next;
      r_res_lo <= w_res_lo_next;
      r_res_ok <= w_res_ok_next;
    end
  end

  // Next-state and datapath selection; start is only looked at in IDLE
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_busy_next   = r_busy;
    w_hi_next     = r_hi;
    w_lo_next     = r_lo;
    w_res_hi_next = r_res_hi;
    w_res_lo_next = r_res_lo;
    w_res_ok_next = r_res_ok;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (w_op)
            MD_MULT, MD_MULTU: begin
              w_res_hi_next = (w_op == MD_MULT) ? w_prod_s[63:32] : w_prod_u[63:32];
              w_res_lo_next = (w_op == MD_MULT) ? w_prod_s[31:0]  : w_prod_u[31:0];
              w_res_ok_next = 1'b1;
              w_cnt_next    = MUL_CNT;
              w_busy_next   = 1'b1;
              w_state_next  = ST_MUL;
            end
            MD_DIV, MD_DIVU: begin
              w_res_hi_next = (w_op == MD_DIV) ? w_rem_s : w_rem_u;
              w_res_lo_next = (w_op == MD_DIV) ? w_quo_s : w_quo_u;
              w_res_ok_next = !w_div_zero;
              w_cnt_next    = DIV_CNT;
              w_busy_next   = 1'b1;
              w_state_next  = ST_DIV;
            end
            MD_MTHI: w_hi_next = a;
            MD_MTLO: w_lo_next = a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == 4'd0) begin
          if (r_res_ok) begin
            w_hi_next = r_res_hi;
            w_lo_next = r_res_lo;
          end
          w_busy_next  = 1'b0;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: hand-computed HI/LO results and busy lengths.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue one request, then wait (bounded) until busy drops; returns busy cycles
  task automatic run_op(input logic [2:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, output int cycles);
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    cycles = 0;
    while (busy && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    $display("op=%0d a=%08h b=%08h cycles=%0d hi=%08h lo=%08h", op_i, a_i, b_i, cycles, hi, lo);
  endtask

  int cyc;
  logic [31:0] hold_hi;

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    run_op(MD_MTHI, 32'h1234_5678, 32'd0, cyc);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_cyc", cyc, 32'd0);

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, cyc);
    chk("mult_cyc", cyc, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, cyc);
    chk("multu_cyc", cyc, 32'd5);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("div_cyc", cyc, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op(MD_DIVU, 32'd7, 32'd2, cyc);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    run_op(MD_MTHI, 32'hAAAA_0000, 32'd0, cyc);
    run_op(MD_MTLO, 32'h0000_BBBB, 32'd0, cyc);
    chk("mtlo_lo", lo, 32'h0000_BBBB);
    run_op(MD_DIV, 32'd5, 32'd0, cyc);
    chk("dz_cyc", cyc, 32'd10);
    chk("dz_hi", hi, 32'hAAAA_0000);
    chk("dz_lo", lo, 32'h0000_BBBB);
    run_op(MD_DIVU, 32'd5, 32'd0, cyc);
    chk("dzu_hi", hi, 32'hAAAA_0000);
    chk("dzu_lo", lo, 32'h0000_BBBB);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // Undefined op code: nothing happens
    run_op(3'd7, 32'd1, 32'd1, cyc);
    chk("undef_busy", {31'd0, busy}, 32'd0);
    chk("undef_hi", hi, 32'd0);
    chk("undef_lo", lo, 32'h8000_0000);

    // DIV with a stray MULT start in its second busy cycle
    @(negedge clk);
    start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    cyc = 0;
    @(posedge clk); #1; cyc++;
    @(negedge clk);
    start = 1'b1; op = MD_MULT; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; cyc++;
    start = 1'b0; op = 3'd0;
    hold_hi = hi;
    while (busy && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) chk("busy_hold_hi", hi, hold_hi);
    end
    $display("div with ignored start: cycles=%0d hi=%08h lo=%08h", cyc, hi, lo);
    chk("ign_cyc", cyc, 32'd10);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);

    // Back-to-back: issued in the first idle cycle
    run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, cyc);
    chk("b2b_cyc", cyc, 32'd5);
    chk("b2b_hi", hi, 32'd1);
    chk("b2b_lo", lo, 32'd0);

    // Reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; op = MD_MULT; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    $display("after mid-mult reset: busy=%0d hi=%08h lo=%08h", busy, hi, lo);
    chk("late_busy", {31'd0, busy}, 32'd0);
    chk("late_hi", hi, 32'd0);
    chk("late_lo", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
